// File: rtl/fft_framer_pkg.sv
// Shared spectrum-path constants.
// The window and FFT stages import the same sample width and frame length,
// so all three stages agree on the frame geometry. Also holds the
// decimation-ratio normalisation used by the framer.
package fft_framer_pkg;

  localparam int SAMPLE_W          = 16;   // ADC sample width, signed
  localparam int FRAME_LEN_DEFAULT = 1024; // samples per FFT frame
  localparam int DEC_W             = 8;    // decimation ratio field width
  localparam int DROP_W            = 16;   // dropped-sample counter width

  // Ratios 0 and 1 both mean "keep every sample".
  function automatic logic [DEC_W-1:0] eff_ratio(input logic [DEC_W-1:0] ratio);
    return (ratio < DEC_W'(2)) ? DEC_W'(1) : ratio;
  endfunction

endpackage

// File: rtl/fft_framer_fifo.sv
// Synchronous show-ahead FIFO with a registered output stage.
// Total capacity is DEPTH entries: DEPTH-1 in the memory array plus the
// output register, which doubles as the registered memory read.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   i_wr, i_wr_data  write strobe and data (ignored while o_full)
//   o_full           no room for a write this cycle (already accounts for
//                    a read in the same cycle, so a full FIFO being read
//                    still accepts the write)
//   i_rd             consume the head entry (downstream ready)
//   o_valid          head entry present (FIFO not empty)
//   o_rd_data        head entry
module fft_framer_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int MEM_DEPTH = DEPTH - 1;
  localparam int AW        = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic w_mem_empty;
  logic w_mem_full;
  logic w_load;
  logic w_wr;

  // Memory depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(MEM_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_mem_empty = (r_count == '0);
  assign w_mem_full  = (r_count == AW'(MEM_DEPTH));
  // Refill the output register whenever it is empty or being consumed.
  assign w_load      = !w_mem_empty && (!r_out_valid || i_rd);
  assign o_full      = w_mem_full && !w_load;
  assign w_wr        = i_wr && !o_full;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_load) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + AW'(w_wr) - AW'(w_load);
      if (w_load) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (i_rd) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_out_valid;
  assign o_rd_data = r_out_data;

endmodule

// File: rtl/fft_framer.sv
// Spectrum-path framer: decimates a free-running ADC stream, cuts it into
// FRAME_LEN-sample frames marked with tlast and buffers them for a
// stallable AXI-Stream output. When the FIFO is full a kept sample is
// dropped without advancing the frame index, so frames are always exactly
// FRAME_LEN long; the loss is flagged on the frame's tlast beat (tuser) and
// counted in drop_cnt.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   enable               start/stop framing (stop completes the frame)
//   dec_ratio            keep 1 of every dec_ratio valid samples
//   adc_data, adc_valid  input sample stream, no backpressure
//   tdata_m, tvalid_m, tlast_m, tuser_m, tready_m   AXI-Stream master
//   busy                 framer not idle
//   drop_cnt             dropped samples since the last start, saturating
module fft_framer
  import fft_framer_pkg::*;
#(
  parameter int DW         = SAMPLE_W,
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DEC_W-1:0]  dec_ratio,
  input  logic [DW-1:0]     adc_data,
  input  logic              adc_valid,
  output logic [DW-1:0]     tdata_m,
  output logic              tvalid_m,
  output logic              tlast_m,
  output logic              tuser_m,
  input  logic              tready_m,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int IW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [DW-1:0]     r_in_data;
  logic              r_in_valid;
  logic [DEC_W-1:0]  r_ratio;
  logic [DEC_W-1:0]  r_dec_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_err;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_start;
  logic              w_proc;
  logic              w_keep;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic              w_last;
  logic              w_frame_start_wr;
  logic [DEC_W-1:0]  w_ratio;
  logic              w_wr_user;
  logic [DW+1:0]     w_wr_data;
  logic [DW+1:0]     w_rd_data;

  assign w_start          = (r_state == ST_IDLE) && enable;
  assign w_proc           = r_in_valid && (r_state != ST_IDLE);
  assign w_keep           = w_proc && (r_dec_cnt == '0);
  assign w_wr             = w_keep && !w_full;
  assign w_drop           = w_keep && w_full;
  assign w_last           = (r_idx == IW'(FRAME_LEN - 1));
  assign w_frame_start_wr = w_wr && (r_idx == '0);
  // The first write of a frame picks up the current dec_ratio, and the
  // counter step taken on that same pulse already uses it.
  assign w_ratio          = w_frame_start_wr ? eff_ratio(dec_ratio) : r_ratio;
  assign w_wr_user        = w_last && r_err;
  assign w_wr_data        = {w_wr_user, w_last, r_in_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // Stopping on a frame boundary with nothing in flight skips DRAIN.
          if ((w_wr && w_last) || ((r_idx == '0) && !w_keep)) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_wr && w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_ratio    <= DEC_W'(1);
      r_dec_cnt  <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_in_data  <= adc_data;
      r_in_valid <= adc_valid;
      if (w_start) begin
        r_ratio    <= eff_ratio(dec_ratio);
        r_dec_cnt  <= '0;
        r_idx      <= '0;
        r_err      <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        // Every valid pulse advances the decimator, kept or dropped.
        if (w_proc) begin
          r_dec_cnt <= (r_dec_cnt == w_ratio - DEC_W'(1)) ? '0 : r_dec_cnt + DEC_W'(1);
        end
        if (w_frame_start_wr) begin
          r_ratio <= w_ratio;
        end
        if (w_wr) begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_err <= 1'b0;
          end
        end
        if (w_drop) begin
          r_err <= 1'b1;
          if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
          end
        end
      end
    end
  end

  fft_framer_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr      (w_wr),
    .i_wr_data (w_wr_data),
    .o_full    (w_full),
    .i_rd      (tready_m),
    .o_valid   (tvalid_m),
    .o_rd_data (w_rd_data)
  );

  assign tdata_m  = w_rd_data[DW-1:0];
  assign tlast_m  = w_rd_data[DW];
  assign tuser_m  = w_rd_data[DW+1];
  assign busy     = (r_state != ST_IDLE);
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fft_framer.sv
// Scoreboard bench for fft_framer (FRAME_LEN=8, FIFO_DEPTH=4).
// Stimulus pushes hand-derived expected beats {data,last,user}; a monitor
// pops and compares on every output handshake and checks AXI hold rules.
module tb_fft_framer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  dec_ratio;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [15:0] tdata_m;
  logic        tvalid_m;
  logic        tlast_m;
  logic        tuser_m;
  logic        tready_m;
  logic        busy;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 1;          // 0: ready low, 1: ready high, 2: low 1-of-3
  int first_rise_cyc = -1;
  int lat_start = 0;
  int n_beats = 0;
  logic [17:0] exp_q[$];

  fft_framer #(
    .DW         (16),
    .FRAME_LEN  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .dec_ratio (dec_ratio),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .tdata_m   (tdata_m),
    .tvalid_m  (tvalid_m),
    .tlast_m   (tlast_m),
    .tuser_m   (tuser_m),
    .tready_m  (tready_m),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input bit l, input bit u);
    exp_q.push_back({16'(d), l, u});
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (6) step();
  endtask

  // Ready driver: the only process that drives tready_m.
  initial begin
    tready_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tready_m = 1'b0;
        1:       tready_m = 1'b1;
        default: tready_m = (cyc % 3) != 0;
      endcase
    end
  end

  // Monitor: compares each handshake beat against the scoreboard.
  initial begin
    logic        stall_prev;
    logic [17:0] stall_beat;
    logic [17:0] exp_beat;
    logic        valid_prev;
    stall_prev = 1'b0;
    stall_beat = '0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
        valid_prev = 1'b0;
        continue;
      end
      if (tvalid_m && !valid_prev && first_rise_cyc < 0) first_rise_cyc = cyc;
      valid_prev = tvalid_m;
      if (stall_prev) begin
        check("hold_valid", 32'(tvalid_m), 32'd1);
        check("hold_beat", 32'({tdata_m, tlast_m, tuser_m}), 32'(stall_beat));
      end
      if (tvalid_m && tready_m) begin
        n_beats++;
        $display("[TB] beat %0d data=%0d last=%0b user=%0b", n_beats, tdata_m, tlast_m, tuser_m);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data=%0d last=%0b user=%0b with no beat expected",
                   tdata_m, tlast_m, tuser_m);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", 32'({tdata_m, tlast_m, tuser_m}), 32'(exp_beat));
        end
      end
      stall_prev = tvalid_m && !tready_m;
      stall_beat = {tdata_m, tlast_m, tuser_m};
    end
  end

  initial begin
    int v;
    reset_n = 1'b0; enable = 1'b0; dec_ratio = 8'd1;
    adc_data = '0; adc_valid = 1'b0; rdy_mode = 1;
    repeat (3) step();
    check("rst_tdata", 32'(tdata_m), 0);
    check("rst_tvalid", 32'(tvalid_m), 0);
    check("rst_tlast", 32'(tlast_m), 0);
    check("rst_tuser", 32'(tuser_m), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    reset_n = 1'b1;
    step();

    // Basic frames: ramp 0..23, tlast on 7/15/23, first beat 3 edges after drive.
    enable = 1'b1; step(); step();
    for (int i = 0; i < 24; i++) begin
      step();
      adc_valid = 1'b1; adc_data = 16'(i);
      push(i, (i % 8) == 7, 1'b0);
      if (i == 0) lat_start = cyc;
    end
    step(); adc_valid = 1'b0; enable = 1'b0;
    wait_empty("basic");
    check("basic_latency", 32'(first_rise_cyc - lat_start), 32'd3);
    check("basic_busy", 32'(busy), 0);
    check("basic_drop", 32'(drop_cnt), 0);

    // Decimation by 3: keep 0,3,6,...; tlast on 21 and 45.
    dec_ratio = 8'd3; enable = 1'b1; step(); step();
    for (int i = 0; i < 48; i++) begin
      step();
      adc_valid = 1'b1; adc_data = 16'(i);
      if (i % 3 == 0) push(i, ((i / 3) % 8) == 7, 1'b0);
    end
    step(); adc_valid = 1'b0; enable = 1'b0;
    wait_empty("decim");
    check("decim_busy", 32'(busy), 0);

    // Backpressure: samples every other cycle, ready low one cycle in three.
    dec_ratio = 8'd1; rdy_mode = 2; enable = 1'b1; step(); step();
    for (int i = 0; i < 16; i++) begin
      step(); adc_valid = 1'b1; adc_data = 16'(50 + i);
      push(50 + i, (i % 8) == 7, 1'b0);
      step(); adc_valid = 1'b0;
    end
    enable = 1'b0;
    wait_empty("bp");
    check("bp_drop", 32'(drop_cnt), 0);
    rdy_mode = 1;

    // Stop mid-frame: deassert during index 3, frame completes to index 7.
    enable = 1'b1; step(); step();
    for (int i = 0; i < 12; i++) begin
      step(); adc_valid = 1'b1; adc_data = 16'(300 + i);
      if (i < 8) push(300 + i, i == 7, 1'b0);
      if (i == 3) enable = 1'b0;
      if (i == 8) check("stop_busy_before", 32'(busy), 1);
      if (i == 9) check("stop_busy_after", 32'(busy), 0);
    end
    step(); adc_valid = 1'b0;
    wait_empty("stop");

    // Overflow: capacity 4, ready low for 20 samples -> samples 4..19 dropped.
    rdy_mode = 0; enable = 1'b1; step(); step(); step();
    for (int i = 0; i < 40; i++) begin
      step(); adc_valid = 1'b1; adc_data = 16'(500 + i);
      if (i < 4 || i >= 20) push(500 + i, (i == 23) || (i == 31) || (i == 39), i == 23);
      if (i == 20) rdy_mode = 1;
    end
    enable = 1'b0;
    v = 40;
    while (busy && v < 80) begin
      step(); adc_data = 16'(500 + v); v++;
    end
    step(); adc_valid = 1'b0;
    check("ovf_busy", 32'(busy), 0);
    wait_empty("ovf");
    check("ovf_drop", 32'(drop_cnt), 32'd16);

    // Reset mid-frame: outputs clear at once, next frame starts clean.
    enable = 1'b1; step(); step();
    for (int i = 0; i < 6; i++) begin
      step(); adc_valid = 1'b1; adc_data = 16'(700 + i);
      push(700 + i, 1'b0, 1'b0);
    end
    step(); adc_valid = 1'b0;
    check("rst_mid_pre_valid", 32'(tvalid_m), 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_tvalid", 32'(tvalid_m), 0);
    check("rst_mid_tdata", 32'(tdata_m), 0);
    check("rst_mid_tlast", 32'(tlast_m), 0);
    check("rst_mid_tuser", 32'(tuser_m), 0);
    check("rst_mid_busy", 32'(busy), 0);
    repeat (3) step();
    reset_n = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      step(); adc_valid = 1'b1; adc_data = 16'(800 + i);
      push(800 + i, i == 7, 1'b0);
    end
    step(); adc_valid = 1'b0; enable = 1'b0;
    wait_empty("rst_mid");
    check("rst_mid_drop", 32'(drop_cnt), 0);
    check("rst_mid_busy_end", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
